hpdcache_sram_1rw_req: RTL and testbench
========================================

Name: hpdcache_sram_1rw_req

Overview:
- Requester-side controller that drives a single-port 1RW cache SRAM macro: cs, we, addr, wdata out; rdata back with fixed 1-cycle read latency.
- Converts a valid/ready request stream (read or write) into SRAM accesses.
- Captures read data in the cycle after the access and returns it through a response FIFO with backpressure.
- Sits between the HPDcache data/dir pipeline and each SRAM cut.

Parameters:
- ADDR_SIZE, 6, SRAM address width.
- DATA_SIZE, 64, SRAM word width.
- DEPTH, 2**ADDR_SIZE, number of SRAM words; legal range 1..2**ADDR_SIZE.
- RSP_DEPTH, 3, response FIFO entries; also the maximum number of reads in flight plus buffered. Minimum 1; 3 gives full read throughput.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_SIZE  request address
- req_wdata  in  DATA_SIZE  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  DATA_SIZE  read data
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_SIZE  SRAM address
- sram_wdata  out  DATA_SIZE  SRAM write data
- sram_rdata  in  DATA_SIZE  SRAM read data, valid the cycle after cs&~we
- init_done  out  1  controller accepting requests

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assertion, active-low. Polarity and synchronicity are fixed.
- Reset values:
  - req_ready=0 while rst_n low.
  - rsp_valid=0, rsp_rdata=0.
  - sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - credit count=0, rd_pending=0, FIFO empty.
  - init_done per the optional feature.
- SRAM side is combinational from the accepted request:
  - sram_cs = req_valid & req_ready.
  - sram_we, sram_addr, sram_wdata = req_we, req_addr, req_wdata.
  - At most one SRAM access per cycle.
- req_ready = init_done & (credit < RSP_DEPTH), registered state only; no combinational path from rsp_ready. The same condition gates writes and reads, so request order is preserved.
- credit:
  - +1 on an accepted read.
  - -1 on rsp_valid&rsp_ready.
  - Both in the same cycle: unchanged.
  - Writes never touch credit.
- rd_pending register is set in the cycle after an accepted read. When set, sram_rdata is pushed into the FIFO at the end of that cycle. sram_rdata is ignored in every other cycle.
- Read latency: accept at cycle N → rsp_valid at N+2 (FIFO empty, rsp_ready high).
- Throughput with RSP_DEPTH=3 and rsp_ready held high: one read per cycle sustained.
- The FIFO cannot overflow by construction. A push with the FIFO full is an assertion failure.
- Responses return in request order. rsp_rdata is stable while rsp_valid&~rsp_ready.
- Writes produce no response. A read immediately following a write to the same address returns the new data, because the SRAM serializes accesses.
- Address wrap: no wrap logic. req_addr ≥ DEPTH is illegal and flagged by an assertion.
- Reset mid-operation: in-flight read and buffered responses are discarded. No SRAM access is issued while rst_n is low.

Optional Feature:
- Macro: HPDCACHE_SRAM_INIT_EN.
- Defined:
  - FSM with states INIT and RUN; reset enters INIT with init_done=0, req_ready=0.
  - INIT drives sram_cs=1, sram_we=1, sram_wdata=0, sram_addr=init counter, starting at 0 and +1 per cycle.
  - After writing DEPTH-1, the next cycle enters RUN, init_done=1.
  - Total INIT duration is DEPTH cycles after reset release.
  - Reset during INIT restarts the sweep from 0.
- Undefined: no FSM; init_done=0 only while rst_n low, then 1 from the first clock edge after release. SRAM contents are unmodified.

Test Plan:
- Single read: with 0xA5A5 preloaded at addr 5, read addr 5 at cycle N → sram_cs=1, sram_we=0, sram_addr=5 at N; rsp_valid=1, rsp_rdata=0xA5A5 at N+2.
- Write then read: write 0x1234 to addr 3, next cycle read addr 3 → one response, rsp_rdata=0x1234, no response for the write.
- Streaming: 8 back-to-back reads of addr 0..7 with rsp_ready=1 → req_ready never drops, 8 in-order responses on 8 consecutive cycles.
- Backpressure: rsp_ready=0, issue 5 reads → exactly 3 accepted, req_ready=0 after the 3rd, rsp_rdata held. Then rsp_ready=1 → remaining 2 accepted, all 5 return in order.
- Reset mid-flight: assert rst_n=0 one cycle after a read is accepted → rsp_valid=0 immediately, no response after release, credit=0.
- With HPDCACHE_SRAM_INIT_EN and DEPTH=64: after reset release, 64 write cycles to addr 0..63 with data 0, then init_done=1. A read of addr 10 returns 0.

Source files
------------

// File: rtl/hpdcache_sram_1rw_req.sv
// hpdcache_sram_1rw_req
// Requester-side controller for a single-port 1RW cache SRAM cut.
// - Accepts a valid/ready request stream of reads and writes.
// - Turns each accepted request into one SRAM access in the same cycle.
// - Captures read data one cycle after the access.
// - Returns read data in order through a small response FIFO with backpressure.
// Read credits bound the reads in flight plus buffered, so the FIFO never overflows.
//
// Optional feature: define HPDCACHE_SRAM_INIT_EN to zero-fill the whole SRAM
// after reset. The sweep is driven by an INIT/RUN state machine and takes
// DEPTH cycles; requests are held off until it completes.
module hpdcache_sram_1rw_req #(
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_rdata,

    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0] sram_wdata,
    input  logic [DATA_SIZE-1:0] sram_rdata,

    output logic                 init_done
);

    // Pointer width is kept at least 1 so a single-entry FIFO still elaborates.
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Initialization control
    // ------------------------------------------------------------------
    logic                 init_done_w;
    logic                 init_active;
    logic [ADDR_SIZE-1:0] init_addr;

`ifdef HPDCACHE_SRAM_INIT_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_SIZE-1:0] INIT_LAST = ADDR_SIZE'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] init_cnt_q, init_cnt_d;

    // State and sweep-address registers; reset always restarts the sweep at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state: one zero-write per INIT cycle, then RUN after the last word.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_active = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_active = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_SIZE'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    assign init_done_w = (state_q == ST_RUN);
    assign init_addr   = init_cnt_q;
`else
    logic init_done_q;

    // Ready from the first clock edge after reset release; no sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end

    assign init_done_w = init_done_q;
    assign init_active = 1'b0;
    assign init_addr   = '0;
`endif

    assign init_done = init_done_w;

    // ------------------------------------------------------------------
    // Request acceptance and read credits
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             rd_pending_q, rd_pending_d;

    logic             req_fire;
    logic             rd_fire;
    logic             rsp_fire;

    // Ready depends on registered state only, never on rsp_ready. Writes are
    // gated by the same condition as reads so request order is preserved.
    assign req_ready = init_done_w && (credit_q < CNT_MAX);
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_we;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Credits: +1 per accepted read, -1 per consumed response.
    always_comb begin
        credit_d     = credit_q;
        rd_pending_d = rd_fire;
        case ({rd_fire, rsp_fire})
            2'b10:   credit_d = credit_q + CNT_ONE;
            2'b01:   credit_d = credit_q - CNT_ONE;
            default: credit_d = credit_q;
        endcase
    end

    // Credit counter and read-in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    // ------------------------------------------------------------------
    // SRAM port
    // ------------------------------------------------------------------
    // Address and data are zeroed when no access is made, which also gives
    // the required all-zero port while reset is asserted. During the init
    // sweep chip select is qualified with rst_n. This stops a write from being
    // issued while the state machine is held in INIT by reset.
    always_comb begin
        sram_cs    = req_fire;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (init_active) begin
            sram_cs    = rst_n;
            sram_we    = rst_n;
            sram_addr  = rst_n ? init_addr : '0;
            sram_wdata = '0;
        end else if (req_fire) begin
            sram_we    = req_we;
            sram_addr  = req_addr;
            sram_wdata = req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] fifo_mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;

    logic                 push;
    logic                 pop;

    // sram_rdata is only meaningful in the cycle after a read access.
    assign push = rd_pending_q;
    assign pop  = rsp_fire;

    // Pointer and occupancy update with wrap at RSP_DEPTH-1.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO control registers; reset discards every buffered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= sram_rdata;
        end
    end

    // The head entry is only overwritten after it is popped, so the data is
    // stable while the consumer stalls. Output is zero whenever the FIFO is empty.
    assign rsp_valid = (fifo_cnt_q != '0);
    assign rsp_rdata = rsp_valid ? fifo_mem_q[rd_ptr_q] : '0;

    // ------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    // Credits must stop the FIFO from being written while it is full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_cnt_q != CNT_MAX));

    // The design has no wrap logic, so addresses beyond the cut are illegal.
    a_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        req_fire |-> (32'(req_addr) < DEPTH));

    // A response can only be consumed against an outstanding credit.
    a_credit_nonneg: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_fire |-> (credit_q != '0));
`endif

endmodule

// File: tb/tb_hpdcache_sram_1rw_req.sv
// Table-driven bench for hpdcache_sram_1rw_req with a behavioural 1RW SRAM.
// When no read is issued, the SRAM model drives junk on its read-data bus.
module tb_hpdcache_sram_1rw_req;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          init_done;

    hpdcache_sram_1rw_req #(
        .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH), .RSP_DEPTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: one-cycle read latency, junk on the bus otherwise.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
        else sram_rdata <= {$urandom, $urandom};
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic          rr;
        logic          e_ready;
        logic          e_cs;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic rr, input logic e_ready,
                                input logic e_cs, input logic e_rv, input logic [DW-1:0] e_rd);
        vec_t r;
        r.v = v; r.we = we; r.a = a; r.wd = wd; r.rr = rr;
        r.e_ready = e_ready; r.e_cs = e_cs; r.e_rv = e_rv; r.e_rd = e_rd;
        tbl.push_back(r);
    endfunction

    // Expected SRAM contents after the write of 0x1234 to address 3.
    function automatic logic [DW-1:0] dat(input int a);
        if (a == 3) return 64'h1234;
        if (a == 5) return 64'hA5A5;
        return 64'h100 + 64'(a);
    endfunction

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'h100 + 64'(i);
        mem[5] = 64'hA5A5;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic rr);
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd; rsp_ready = rr;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        logic seen;
        logic [DW-1:0] got [3];
        logic [AW-1:0] addrs [4];

        for (int i = 0; i < DEPTH; i++) mem[i] = 64'hDEAD_0000 + 64'(i);
        sram_rdata = '0;

        // ---------------- reset values, with an active-looking request applied ----------------
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd9; req_wdata = 64'hFFFF; rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_sram_cs", 64'(sram_cs), 64'd0);
        chk("rst_sram_we", 64'(sram_we), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("rst_sram_wdata", sram_wdata, 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);

        drive(1'b0, 1'b0, '0, '0, 1'b1);
        rst_n = 1'b1;
        #1;
`ifdef HPDCACHE_SRAM_INIT_EN
        // Zero-fill sweep: DEPTH write cycles to consecutive addresses.
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk($sformatf("init_cyc%0d", i),
                {init_done, req_ready, sram_cs, sram_we, sram_wdata[3:0], 2'b00, sram_addr},
                {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 2'b00, 6'(i)});
        end
        @(negedge clk); #1;
        chk("init_done_after_sweep", 64'(init_done), 64'd1);
        chk("init_mem_zero", mem[63] | mem[0], 64'd0);
        drive(1'b1, 1'b0, 6'd10, '0, 1'b1);
        chk("init_rd10_cs", 64'(sram_cs), 64'd1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("init_rd10_valid", 64'(rsp_valid), 64'd1);
        chk("init_rd10_data", rsp_rdata, 64'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
`else
        chk("init_done_before_edge", 64'(init_done), 64'd0);
        @(negedge clk); #1;
        chk("init_done_after_edge", 64'(init_done), 64'd1);
        chk("req_ready_after_edge", 64'(req_ready), 64'd1);
`endif
        preload();

        // ---------------- table ----------------
        // Single read of addr 5: the response appears two cycles later.
        add(1,0,6'd5,0,1, 1,1,0,0);
        add(0,0,0,0,1,    1,0,0,0);
        add(0,0,0,0,1,    1,0,1,64'hA5A5);
        add(0,0,0,0,1,    1,0,0,0);
        // Write then read the same address: one response only.
        add(1,1,6'd3,64'h1234,1, 1,1,0,0);
        add(1,0,6'd3,0,1,        1,1,0,0);
        add(0,0,0,0,1,           1,0,0,0);
        add(0,0,0,0,1,           1,0,1,64'h1234);
        add(0,0,0,0,1,           1,0,0,0);
        // Streaming: 8 back-to-back reads, ready stays high.
        for (int i = 0; i < 8; i++)
            add(1,0,6'(i),0,1, 1,1, (i >= 2), (i >= 2) ? dat(i-2) : 64'd0);
        add(0,0,0,0,1, 1,0,1,dat(6));
        add(0,0,0,0,1, 1,0,1,dat(7));
        add(0,0,0,0,1, 1,0,0,0);
        // Backpressure: three reads accepted, the rest wait for credits.
        add(1,0,6'd0,0,0, 1,1,0,0);
        add(1,0,6'd1,0,0, 1,1,0,0);
        add(1,0,6'd2,0,0, 1,1,1,dat(0));
        add(1,0,6'd4,0,0, 0,0,1,dat(0));
        add(1,0,6'd4,0,0, 0,0,1,dat(0));
        add(1,0,6'd4,0,1, 0,0,1,dat(0));
        add(1,0,6'd4,0,1, 1,1,1,dat(1));
        add(1,0,6'd6,0,1, 1,1,1,dat(2));
        add(0,0,0,0,1,    1,0,1,dat(4));
        add(0,0,0,0,1,    1,0,1,dat(6));
        add(0,0,0,0,1,    1,0,0,0);

        foreach (tbl[r]) begin
            drive(tbl[r].v, tbl[r].we, tbl[r].a, tbl[r].wd, tbl[r].rr);
            chk($sformatf("row%0d_ready", r), 64'(req_ready), 64'(tbl[r].e_ready));
            chk($sformatf("row%0d_cs", r), 64'(sram_cs), 64'(tbl[r].e_cs));
            chk($sformatf("row%0d_rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].e_rv));
            if (tbl[r].e_rv) chk($sformatf("row%0d_rdata", r), rsp_rdata, tbl[r].e_rd);
            if (tbl[r].e_cs) begin
                chk($sformatf("row%0d_sram_we", r), 64'(sram_we), 64'(tbl[r].we));
                chk($sformatf("row%0d_sram_addr", r), 64'(sram_addr), 64'(tbl[r].a));
                if (tbl[r].we) chk($sformatf("row%0d_sram_wdata", r), sram_wdata, tbl[r].wd);
            end
            $display("row %0d: v=%0b we=%0b a=%0d rr=%0b -> ready=%0b cs=%0b rv=%0b rd=%h",
                     r, tbl[r].v, tbl[r].we, tbl[r].a, tbl[r].rr, req_ready, sram_cs, rsp_valid, rsp_rdata);
        end

        // ---------------- reset one cycle after an accepted read ----------------
        drive(1'b1, 1'b0, 6'd7, '0, 1'b1);
        chk("mid_rd_cs", 64'(sram_cs), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_cs", 64'(sram_cs), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        chk("mid_rst_rsp_valid2", 64'(rsp_valid), 64'd0);
        chk("mid_rst_cs2", 64'(sram_cs), 64'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        rst_n = 1'b1;
        #1;
        seen = rsp_valid;
        for (int c = 0; c < DEPTH + 4 && !init_done; c++) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
        end
        chk("mid_rst_init_done", 64'(init_done), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
        end
        chk("mid_rst_no_response", 64'(seen), 64'd0);
        $display("reset mid-flight: spurious response seen=%0b", seen);

        // Credits restart at 0: exactly three reads fit with the consumer stalled.
        preload();
        addrs[0] = 6'd1; addrs[1] = 6'd2; addrs[2] = 6'd3; addrs[3] = 6'd4;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, addrs[(k < 4) ? k : 3], '0, 1'b0);
            if (req_ready && k < 4) k++;
        end
        chk("post_rst_accepts", 64'(k), 64'd3);
        $display("post-reset: %0d reads accepted with rsp_ready low", k);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1);
            if (rsp_valid) begin
                if (n < 3) got[n] = rsp_rdata;
                n++;
            end
        end
        chk("post_rst_rsp_count", 64'(n), 64'd3);
        chk("post_rst_rsp0", got[0], 64'h101);
        chk("post_rst_rsp1", got[1], 64'h102);
        chk("post_rst_rsp2", got[2], 64'h103);
        $display("post-reset drain: %0d responses %h %h %h", n, got[0], got[1], got[2]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
